// File: rtl/led_chaser_param.sv
// Parametrised LED chaser: rotate, bounce and fill/drain patterns with a step
// prescaler and registered step/wrap pulses for chaining several banks.
module led_chaser_param #(
  parameter int WIDTH = 8,
  parameter int RUN   = 2,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);

  // mode_q | meaning
  // ROL    | RUN-wide window rotating towards the MSB
  // ROR    | RUN-wide window rotating towards the LSB
  // BOUNCE | non-wrapping window sweeping up and back down
  // FILL   | bar graph filling to WIDTH then draining to 0
  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0]    CNT_TOP    = CW'(DIV - 1);
  localparam logic [PW-1:0]    POS_LAST   = PW'(WIDTH - 1);
  localparam logic [PW-1:0]    BOUNCE_TOP = PW'(WIDTH - RUN);
  localparam logic [PW-1:0]    FILL_TOP   = PW'(WIDTH);
  localparam logic [WIDTH-1:0] HOME       = WIDTH'((64'd1 << RUN) - 64'd1);

  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             tick;

  // Double-width shift then fold the upper half back in gives a circular rotate.
  function automatic logic [WIDTH-1:0] window(input logic [PW-1:0] p);
    logic [2*WIDTH-1:0] t;
    t = {{WIDTH{1'b0}}, HOME} << p;
    return t[WIDTH-1:0] | t[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] level(input logic [PW-1:0] p);
    return ~({WIDTH{1'b1}} << p);
  endfunction

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    led_d  = led_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    tick   = 1'b0;

    if (mode != mode_q) begin
      // a pending tick on a mode change is dropped on purpose
      mode_d = mode_e'(mode);
      cnt_d  = '0;
      pos_d  = '0;
      dir_d  = 1'b0;
      led_d  = (mode_e'(mode) == MODE_FILL) ? '0 : HOME;
    end else if (en) begin
      if (cnt_q == CNT_TOP) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_ROL: begin
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
        MODE_ROR: begin
          if (pos_q == '0) begin
            pos_d  = POS_LAST;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
        MODE_BOUNCE: begin
          if (!dir_q) begin
            pos_d = pos_q + PW'(1);
            if (pos_d == BOUNCE_TOP) dir_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
            if (pos_d == '0) begin
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end
          end
        end
        default: begin
          if (!dir_q) begin
            pos_d = pos_q + PW'(1);
            if (pos_d == FILL_TOP) dir_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
            if (pos_d == '0) begin
              dir_d  = 1'b0;
              wrap_d = 1'b1;
            end
          end
        end
      endcase
      led_d = (mode_q == MODE_FILL) ? level(pos_d) : window(pos_d);
    end
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      mode_q <= MODE_ROL;
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      led_q  <= HOME;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_chaser_param.sv
// Bench for led_chaser_param: four parameter sets driven in parallel, each
// checked every cycle against a step-count model, plus literal pattern checks.
module tb_led_chaser_param;

  localparam int NI = 4;
  localparam int CFG_W [NI] = '{8, 4, 8, 5};
  localparam int CFG_R [NI] = '{2, 2, 2, 3};
  localparam int CFG_D [NI] = '{1, 1, 3, 2};

  logic       clk;
  logic       rs;
  logic       en;
  logic [1:0] mode;

  logic [7:0] led_a;
  logic [3:0] led_b;
  logic [7:0] led_c;
  logic [4:0] led_d;
  logic       step_a, step_b, step_c, step_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  logic [31:0] dled  [NI];
  logic        dstep [NI];
  logic        dwrap [NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  led_chaser_param #(.WIDTH(8), .RUN(2), .DIV(1)) dut_a (
    .clk(clk), .rs(rs), .en(en), .mode(mode), .led(led_a), .step(step_a), .wrap(wrap_a));
  led_chaser_param #(.WIDTH(4), .RUN(2), .DIV(1)) dut_b (
    .clk(clk), .rs(rs), .en(en), .mode(mode), .led(led_b), .step(step_b), .wrap(wrap_b));
  led_chaser_param #(.WIDTH(8), .RUN(2), .DIV(3)) dut_c (
    .clk(clk), .rs(rs), .en(en), .mode(mode), .led(led_c), .step(step_c), .wrap(wrap_c));
  led_chaser_param #(.WIDTH(5), .RUN(3), .DIV(2)) dut_d (
    .clk(clk), .rs(rs), .en(en), .mode(mode), .led(led_d), .step(step_d), .wrap(wrap_d));

  assign dled[0] = 32'(led_a);
  assign dled[1] = 32'(led_b);
  assign dled[2] = 32'(led_c);
  assign dled[3] = 32'(led_d);
  assign dstep[0] = step_a;
  assign dstep[1] = step_b;
  assign dstep[2] = step_c;
  assign dstep[3] = step_d;
  assign dwrap[0] = wrap_a;
  assign dwrap[1] = wrap_b;
  assign dwrap[2] = wrap_c;
  assign dwrap[3] = wrap_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: k counts steps since the last restart, modulo the pattern period;
  // the LED image is derived directly from k.
  typedef struct {
    int          cnt;
    int          k;
    logic [1:0]  mq;
    logic [31:0] led;
    bit          step;
    bit          wrap;
  } ms_t;

  ms_t ms [NI];

  function automatic int period(int w, int r, logic [1:0] m);
    if (m == 2'd2) return 2 * (w - r);
    if (m == 2'd3) return 2 * w;
    return w;
  endfunction

  function automatic logic [31:0] pat(int w, int r, logic [1:0] m, int k);
    int          pos;
    int          p;
    logic [31:0] v;
    v = '0;
    p = period(w, r, m);
    case (m)
      2'd0: pos = k % w;
      2'd1: pos = (w - (k % w)) % w;
      default: begin
        pos = k % p;
        if (pos > p / 2) pos = p - pos;
      end
    endcase
    if (m == 2'd3) begin
      for (int i = 0; i < pos; i++) v[i] = 1'b1;
    end else begin
      for (int i = 0; i < r; i++) v[(pos + i) % w] = 1'b1;
    end
    return v;
  endfunction

  function automatic ms_t mreset(int w, int r);
    ms_t s;
    s.cnt = 0; s.k = 0; s.mq = 2'd0; s.step = 0; s.wrap = 0;
    s.led = pat(w, r, 2'd0, 0);
    return s;
  endfunction

  function automatic ms_t mstep(ms_t s, int w, int r, int d, bit e, logic [1:0] m);
    ms_t n;
    n = s;
    n.step = 0;
    n.wrap = 0;
    if (m != s.mq) begin
      n.mq  = m;
      n.cnt = 0;
      n.k   = 0;
      n.led = pat(w, r, m, 0);
    end else if (e) begin
      if (s.cnt == d - 1) begin
        n.cnt  = 0;
        n.k    = (s.k + 1) % period(w, r, m);
        n.led  = pat(w, r, m, n.k);
        n.step = 1;
        n.wrap = (m == 2'd1) ? (n.k % w == 1) : (n.k == 0);
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rs) begin
    for (int i = 0; i < NI; i++) begin
      if (!rs) ms[i] = mreset(CFG_W[i], CFG_R[i]);
      else     ms[i] = mstep(ms[i], CFG_W[i], CFG_R[i], CFG_D[i], en, mode);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_led%0d", i), dled[i], ms[i].led);
        chk($sformatf("model_step%0d", i), 32'(dstep[i]), 32'(ms[i].step));
        chk($sformatf("model_wrap%0d", i), 32'(dwrap[i]), 32'(ms[i].wrap));
      end
    end
  end

  task automatic wait_n();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [7:0] l, input bit s, input bit w);
    chk({nm, "_led"}, 32'(led_a), 32'(l));
    chk({nm, "_step"}, 32'(step_a), 32'(s));
    chk({nm, "_wrap"}, 32'(wrap_a), 32'(w));
  endtask

  logic [7:0] seq_rol [8];
  logic [7:0] seq_ror [9];
  logic [7:0] seq_bnc [12];
  logic [3:0] seq_fil [8];

  initial begin
    seq_rol = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
    seq_ror = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
    seq_bnc = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0,
                8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
    seq_fil = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

    rs = 1'b1; en = 1'b0; mode = 2'd0;
    #1 rs = 1'b0;
    #1;
    chk_a("reset", 8'h03, 0, 0);
    chk_on = 1;
    wait_n();
    en = 1'b1;
    rs = 1'b1;

    for (int i = 0; i < 8; i++) begin
      wait_n();
      chk_a("rol", seq_rol[i], 1, i == 7);
    end

    wait_n();
    wait_n();
    @(posedge clk);
    #2 rs = 1'b0;
    #1;
    chk_a("async_rst", 8'h03, 0, 0);
    wait_n();
    rs = 1'b1;
    wait_n();
    chk_a("rst_release", 8'h06, 1, 0);

    mode = 2'd1;
    wait_n();
    chk_a("ror_restart", 8'h03, 0, 0);
    for (int i = 0; i < 9; i++) begin
      wait_n();
      chk_a("ror", seq_ror[i], 1, (i == 0) || (i == 8));
    end

    mode = 2'd2;
    wait_n();
    chk_a("bnc_restart", 8'h03, 0, 0);
    for (int i = 0; i < 12; i++) begin
      wait_n();
      chk_a("bnc", seq_bnc[i], 1, i == 11);
    end

    mode = 2'd3;
    wait_n();
    chk("fil_restart_led", 32'(led_b), 32'h0);
    chk("fil_restart_step", 32'(step_b), 32'h0);
    for (int i = 0; i < 8; i++) begin
      wait_n();
      chk("fil_led", 32'(led_b), 32'(seq_fil[i]));
      chk("fil_wrap", 32'(wrap_b), 32'(i == 7));
    end

    // prescaler behaviour on the DIV=3 instance
    rs = 1'b0; mode = 2'd0; en = 1'b1;
    wait_n();
    rs = 1'b1;
    wait_n(); chk("div_s1", 32'(step_c), 0); chk("div_l1", 32'(led_c), 32'h03);
    wait_n(); chk("div_s2", 32'(step_c), 0);
    wait_n(); chk("div_s3", 32'(step_c), 1); chk("div_l3", 32'(led_c), 32'h06);
    wait_n(); chk("div_s4", 32'(step_c), 0);
    wait_n(); chk("div_s5", 32'(step_c), 0);
    wait_n(); chk("div_s6", 32'(step_c), 1); chk("div_l6", 32'(led_c), 32'h0C);
    wait_n(); chk("div_s7", 32'(step_c), 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_n();
      chk("hold_led", 32'(led_c), 32'h0C);
      chk("hold_step", 32'(step_c), 0);
    end
    en = 1'b1;
    wait_n(); chk("resume_s1", 32'(step_c), 0);
    wait_n(); chk("resume_s2", 32'(step_c), 1); chk("resume_led", 32'(led_c), 32'h18);
    wait_n();
    wait_n();
    mode = 2'd2;
    wait_n(); chk("rst_tick_led", 32'(led_c), 32'h03); chk("rst_tick_step", 32'(step_c), 0);
    wait_n(); chk("after_rst_s1", 32'(step_c), 0);
    wait_n(); chk("after_rst_s2", 32'(step_c), 0);
    wait_n(); chk("after_rst_s3", 32'(step_c), 1); chk("after_rst_led", 32'(led_c), 32'h06);

    for (int n = 0; n < 3000; n++) begin
      wait_n();
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        rs = 1'b0;
        wait_n();
        rs = 1'b1;
      end
    end

    wait_n();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_chaser_param.md
# led_chaser_param

Parametrised LED chaser, the next generation of the fixed 8-LED two-lit running light. It drives a WIDTH-bit LED bank from a single clock. The block supports a configurable lit-run length, a step prescaler and four run-time-selectable patterns. It also outputs step and wrap pulses, so a top level can chain or synchronise several banks.

## Interface

Parameters:
- WIDTH, default 8: number of LEDs; legal range 2..32.
- RUN, default 2: number of adjacent lit LEDs in the rotate and bounce modes; legal range 1..WIDTH-1; ignored in fill mode.
- DIV, default 1: clock cycles per pattern step; legal range ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rs  in  1  reset, asynchronous, active-low.
- en  in  1  step enable; while low, the prescaler and pattern hold.
- mode  in  2  pattern select:
  - 00 rotate left
  - 01 rotate right
  - 10 bounce
  - 11 fill/drain
- led  out  WIDTH  registered LED pattern; 1 = lit.
- step  out  1  registered one-cycle pulse; high during the first cycle of each new pattern.
- wrap  out  1  registered one-cycle pulse; asserted with step when the pattern returns to its home position.

## Operation

State:
- prescaler cnt, 0..DIV-1
- position pos, 0..WIDTH
- direction dir: 0 = up, 1 = down
- registered mode mode_q

Reset (rs low, asynchronous):
- cnt=0, pos=0, dir=up, mode_q=00
- led = RUN ones in the low bits (0x03 for the defaults)
- step=0, wrap=0

Tick: when en=1 and cnt=DIV-1, tick=1 and cnt returns to 0. Otherwise, when en=1, cnt increments. When en=0, cnt holds.

Restart: if mode ≠ mode_q on an edge, the block does all of the following on that edge:
- mode_q←mode, pos←0, dir←up, cnt←0
- led←home pattern of the new mode
- step=0, wrap=0

Restart has priority over a coincident tick; that tick is discarded.

Patterns on a tick:
- Rotate left:
  - led = RUN ones occupying bits pos..pos+RUN-1, modulo WIDTH (circular).
  - pos←(pos+1) mod WIDTH.
  - wrap when pos goes WIDTH-1→0.
- Rotate right:
  - Same window as rotate left.
  - pos←(pos-1) mod WIDTH.
  - wrap when pos goes 0→WIDTH-1.
- Bounce:
  - Window is non-wrapping; pos ranges 0..WIDTH-RUN.
  - dir=up: pos+1. On reaching WIDTH-RUN, dir←down.
  - dir=down: pos-1. On reaching 0, dir←up.
  - No dwell at either end.
  - wrap on the tick that makes pos=0.
  - Period is 2·(WIDTH-RUN) steps.
- Fill/drain:
  - pos is a level, 0..WIDTH; led = the low pos bits set.
  - Home is pos=0, all LEDs off.
  - dir=up: pos+1 until WIDTH, then dir←down.
  - dir=down: pos-1 until 0, then dir←up.
  - wrap on the tick that makes pos=0.
  - Period is 2·WIDTH steps.
  - RUN is ignored.

Home patterns:
- Rotate left, rotate right, bounce: RUN ones at the LSBs.
- Fill: all zeros.

Rotate mode swap: changing between 00 and 01 is a restart like any other mode change; there is no on-the-fly reversal.

## Timing

- led, step and wrap all update on the same edge as pos; there is no combinational path from inputs to outputs.
- Step latency: with en held high from a reset release or restart, the first step occurs on the DIV-th rising edge. With DIV=1, the pattern advances on every clock.
- step and wrap are exactly one cycle wide. For DIV=1 with en continuously high, step is continuously high.
- Dropping en mid-count freezes cnt. Raising en again resumes the count; it does not restart it.
- rs assertion mid-operation immediately forces the reset values, independent of clk. Release is sampled on the next edge; a mode≠00 at release causes a restart on the first edge.

## Test plan

- Reset: WIDTH=8, RUN=2, DIV=1, mode=00. Pull rs low mid-run and between clock edges → led=0x03, step=0, wrap=0 at once. Release → first edge gives led=0x06.
- Rotate left, en=1: led steps 03,06,0C,18,30,60,C0,81,03. wrap is high only with the final 03; step is high every cycle.
- Rotate right, from restart: 03,81,C0,60,30,18,0C,06,03. wrap is high with 81, and with each later 81.
- Bounce: 03,06,0C,18,30,60,C0,60,30,18,0C,06,03. wrap is high with the final 03; there are 12 steps per period and no repeated C0.
- Fill, WIDTH=4: led 0,1,3,7,F,7,3,1,0. wrap is high with the final 0.
- DIV=3, mode=00:
  - step arrives every 3rd cycle.
  - Hold en low for 5 cycles after 1 counted cycle → led frozen; the next step comes 2 enabled cycles after en rises.
  - Switch mode to 10 on a tick cycle → led=0x03, step=0, and the next step comes 3 cycles later.
